// File: rtl/decode.sv
// RV32I decode/control unit for a multi-cycle core: IDLE -> DECODE -> EXECUTE -> WRITEBACK.
// Optional macro DECODE_LUI_EN makes LUI legal; otherwise LUI decodes as an illegal NOP.
module decode (
    input  logic        clk,
    input  logic        rst,
    input  logic        instruction_RDY_BSY,
    input  logic [31:0] instruction,
    input  logic [31:0] alu_result,
    output logic [7:0]  alu_opcode,
    output logic [31:0] alu_imm1,
    output logic [31:0] alu_imm2,
    output logic        RF_chip_enable,
    output logic        RF_write_enable,
    input  logic [31:0] RF_reg1_data,
    input  logic [31:0] RF_reg2_data,
    output logic [4:0]  RF_rs1_address,
    output logic [4:0]  RF_rs2_address,
    output logic [4:0]  RF_WR_add,
    output logic [31:0] RF_WriteData
);
    localparam logic [7:0] OP_NOP  = 8'h00, OP_ADD = 8'h01, OP_SUB = 8'h02, OP_SLL = 8'h03,
                           OP_SLT  = 8'h04, OP_SLTU = 8'h05, OP_XOR = 8'h06, OP_SRL = 8'h07,
                           OP_SRA  = 8'h08, OP_OR  = 8'h09, OP_AND = 8'h0A;
    localparam logic [6:0] OPC_R = 7'b0110011, OPC_I = 7'b0010011, OPC_LUI = 7'b0110111;

    typedef enum logic [1:0] {IDLE, DECODE, EXECUTE, WRITEBACK} state_t;
    state_t state, state_nx;

    // rs1 field is not kept here: RF_rs1_address already holds it for the whole instruction.
    logic [26:0] ir;
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [4:0]  shamt, rd;
    logic [11:0] imm12;

    assign opc   = ir[6:0];
    assign rd    = ir[11:7];
    assign f3    = ir[14:12];
    assign shamt = ir[19:15];
    assign imm12 = ir[26:15];
    assign f7    = ir[26:20];

    logic        legal;
    logic [7:0]  op_dec;
    logic [31:0] imm1_dec, imm2_dec;

    function automatic logic [7:0] alu_code(input logic [2:0] fn, input logic alt);
        logic [7:0] c;
        case (fn)
            3'd0:    c = alt ? OP_SUB : OP_ADD;
            3'd1:    c = OP_SLL;
            3'd2:    c = OP_SLT;
            3'd3:    c = OP_SLTU;
            3'd4:    c = OP_XOR;
            3'd5:    c = alt ? OP_SRA : OP_SRL;
            3'd6:    c = OP_OR;
            default: c = OP_AND;
        endcase
        return c;
    endfunction

    always_comb begin
        legal    = 1'b0;
        op_dec   = OP_NOP;
        imm1_dec = RF_reg1_data;
        imm2_dec = RF_reg2_data;
        case (opc)
            OPC_R: begin
                legal  = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
                op_dec = alu_code(f3, f7[5]);
            end
            OPC_I: begin
                if (f3 == 3'd1)
                    legal = (f7 == 7'h00);
                else if (f3 == 3'd5)
                    legal = (f7 == 7'h00) || (f7 == 7'h20);
                else
                    legal = 1'b1;
                // ADDI has no subtract form, so only the shift group honours bit 30.
                op_dec   = alu_code(f3, (f3 == 3'd5) && f7[5]);
                imm2_dec = (f3 == 3'd1 || f3 == 3'd5) ? {27'd0, shamt}
                                                      : {{20{imm12[11]}}, imm12};
            end
`ifdef DECODE_LUI_EN
            OPC_LUI: begin
                legal    = 1'b1;
                op_dec   = OP_ADD;
                imm1_dec = 32'd0;
                imm2_dec = {imm12, RF_rs1_address, f3, 12'd0};
            end
`endif
            default: legal = 1'b0;
        endcase
        if (!legal) op_dec = OP_NOP;
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (instruction_RDY_BSY) state_nx = DECODE;
            DECODE:    state_nx = EXECUTE;
            EXECUTE:   state_nx = WRITEBACK;
            default:   state_nx = IDLE;
        endcase
    end

    // Outputs are registered on the edge that enters the state they belong to.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ir              <= '0;
            alu_opcode      <= '0;
            alu_imm1        <= '0;
            alu_imm2        <= '0;
            RF_chip_enable  <= 1'b0;
            RF_write_enable <= 1'b0;
            RF_rs1_address  <= '0;
            RF_rs2_address  <= '0;
            RF_WR_add       <= '0;
            RF_WriteData    <= '0;
        end else begin
            RF_chip_enable  <= 1'b0;
            RF_write_enable <= 1'b0;
            case (state)
                IDLE: if (instruction_RDY_BSY) begin
                    ir             <= {instruction[31:20], instruction[14:0]};
                    RF_rs1_address <= instruction[19:15];
                    RF_rs2_address <= instruction[24:20];
`ifdef DECODE_LUI_EN
                    RF_chip_enable <= (instruction[6:0] != OPC_LUI);
`else
                    RF_chip_enable <= 1'b1;
`endif
                end
                DECODE: begin
                    alu_opcode <= op_dec;
                    alu_imm1   <= imm1_dec;
                    alu_imm2   <= imm2_dec;
                end
                EXECUTE: begin
                    RF_chip_enable  <= 1'b1;
                    RF_WR_add       <= rd;
                    RF_WriteData    <= alu_result;
                    RF_write_enable <= legal && (rd != 5'd0);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_decode.sv
// Self-checking bench for decode: directed test-plan steps followed by randomized instructions.
module tb_decode;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        instruction_RDY_BSY = 1'b0;
    logic [31:0] instruction = '0;
    logic [31:0] alu_result = '0;
    logic [7:0]  alu_opcode;
    logic [31:0] alu_imm1, alu_imm2;
    logic        RF_chip_enable, RF_write_enable;
    logic [31:0] RF_reg1_data = '0, RF_reg2_data = '0;
    logic [4:0]  RF_rs1_address, RF_rs2_address, RF_WR_add;
    logic [31:0] RF_WriteData;

    int checks = 0;
    int errors = 0;
    logic [7:0]  prev_op = '0;
    logic [4:0]  prev_rd = '0;
    logic [31:0] prev_wd = '0;

    decode dut (
        .clk(clk), .rst(rst),
        .instruction_RDY_BSY(instruction_RDY_BSY), .instruction(instruction),
        .alu_result(alu_result), .alu_opcode(alu_opcode),
        .alu_imm1(alu_imm1), .alu_imm2(alu_imm2),
        .RF_chip_enable(RF_chip_enable), .RF_write_enable(RF_write_enable),
        .RF_reg1_data(RF_reg1_data), .RF_reg2_data(RF_reg2_data),
        .RF_rs1_address(RF_rs1_address), .RF_rs2_address(RF_rs2_address),
        .RF_WR_add(RF_WR_add), .RF_WriteData(RF_WriteData)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: instruction semantics straight from the ISA field rules.
    task automatic model(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2,
                         output logic [7:0] op, output logic [31:0] i1, output logic [31:0] i2,
                         output logic legal, output logic ce_dec);
        logic [7:0] base [8] = '{8'h01, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h09, 8'h0A};
        int f3 = int'(ins[14:12]);
        int f7 = int'(ins[31:25]);
        int v;
        bit shift;
        op = 0; i1 = r1; i2 = r2; legal = 0; ce_dec = 1;
        if (ins[6:0] == 7'b0110011) begin
            legal = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5));
            op = base[f3] + ((f7 == 32) ? 8'd1 : 8'd0);
        end else if (ins[6:0] == 7'b0010011) begin
            shift = (f3 == 1 || f3 == 5);
            legal = !shift || f7 == 0 || (f3 == 5 && f7 == 32);
            op = base[f3] + ((f3 == 5 && ins[30]) ? 8'd1 : 8'd0);
            v = int'(ins[31:20]);
            if (v >= 2048) v -= 4096;
            i2 = shift ? 32'(ins[24:20]) : 32'(v);
        end
`ifdef DECODE_LUI_EN
        else if (ins[6:0] == 7'b0110111) begin
            legal = 1; op = 8'h01; i1 = 0; ce_dec = 0;
            i2 = ins & 32'hFFFFF000;
        end
`endif
        if (!legal) op = 0;
    endtask

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic run(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2,
                       input logic [31:0] res);
        logic [7:0] op; logic [31:0] i1, i2; logic legal, ce_dec, we;
        model(ins, r1, r2, op, i1, i2, legal, ce_dec);
        we = legal && (ins[11:7] != 5'd0);
        instruction_RDY_BSY = 1; instruction = ins;
        RF_reg1_data = r1; RF_reg2_data = r2; alu_result = res;
        cyc();
        instruction_RDY_BSY = 1'($urandom_range(0, 1)); instruction = $urandom;
        chk("dec_ce", RF_chip_enable, ce_dec);
        chk("dec_we", RF_write_enable, 0);
        chk("dec_rs1", RF_rs1_address, ins[19:15]);
        chk("dec_rs2", RF_rs2_address, ins[24:20]);
        chk("dec_op_hold", alu_opcode, prev_op);
        cyc();
        RF_reg1_data = $urandom; RF_reg2_data = $urandom;
        chk("ex_ce", RF_chip_enable, 0);
        chk("ex_we", RF_write_enable, 0);
        chk("ex_op", alu_opcode, op);
        if (legal) begin
            chk("ex_imm1", alu_imm1, i1);
            chk("ex_imm2", alu_imm2, i2);
        end
        chk("ex_wr_hold", RF_WR_add, prev_rd);
        chk("ex_wd_hold", RF_WriteData, prev_wd);
        cyc();
        alu_result = $urandom;
        chk("wb_ce", RF_chip_enable, 1);
        chk("wb_we", RF_write_enable, we);
        chk("wb_wr_add", RF_WR_add, ins[11:7]);
        chk("wb_wdata", RF_WriteData, res);
        chk("wb_rs1_hold", RF_rs1_address, ins[19:15]);
        cyc();
        instruction_RDY_BSY = 0;
        chk("idle_ce", RF_chip_enable, 0);
        chk("idle_we", RF_write_enable, 0);
        chk("idle_op_hold", alu_opcode, op);
        prev_op = op; prev_rd = ins[11:7]; prev_wd = res;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_op"}, alu_opcode, 0);
        chk({tag, "_imm1"}, alu_imm1, 0);
        chk({tag, "_imm2"}, alu_imm2, 0);
        chk({tag, "_ce"}, RF_chip_enable, 0);
        chk({tag, "_we"}, RF_write_enable, 0);
        chk({tag, "_rs1"}, RF_rs1_address, 0);
        chk({tag, "_rs2"}, RF_rs2_address, 0);
        chk({tag, "_wradd"}, RF_WR_add, 0);
        chk({tag, "_wdata"}, RF_WriteData, 0);
    endtask

    initial begin
        logic [31:0] ins;
        logic [6:0]  f7;
        cyc(); cyc();
        chk_zero("rst");
        rst = 1;
        repeat (3) begin
            cyc();
            chk("idle_noreq_ce", RF_chip_enable, 0);
        end

        run(32'h00308113, 5, 0, 8);            // addi x2,x1,3
        chk("addi_op_const", prev_op, 8'h01);
        run(32'h40208133, 10, 4, 6);           // sub x2,x1,x2
        run(32'h4010D093, 32'h80000000, 7, 32'hC0000000); // srai x1,x1,1
        run(32'hFFF00093, 9, 3, 8);            // addi x1,x0,-1
        run(32'h00308013, 5, 0, 8);            // addi x0,x1,3
        run(32'h0000007F, 1, 2, 3);            // illegal opcode
        run(32'h123450B7, 1, 2, 32'h12345000); // lui x1
        run(32'h02208133, 1, 2, 3);            // R-type with bad funct7
        run(32'h4020C133, 1, 2, 3);            // xor with funct7=0x20

        // Reset in EXECUTE: everything clears and no write-back follows.
        instruction_RDY_BSY = 1; instruction = 32'h00308113;
        RF_reg1_data = 5; alu_result = 8;
        cyc();
        instruction_RDY_BSY = 0;
        cyc();
        rst = 0;
        cyc();
        chk_zero("midrst");
        rst = 1;
        repeat (3) begin
            cyc();
            chk("midrst_ce", RF_chip_enable, 0);
            chk("midrst_we", RF_write_enable, 0);
        end
        prev_op = 0; prev_rd = 0; prev_wd = 0;

        for (int n = 0; n < 60; n++) begin
            ins = $urandom;
            case ($urandom_range(0, 5))
                0, 1: ins[6:0] = 7'b0110011;
                2, 3: ins[6:0] = 7'b0010011;
                4:    ins[6:0] = 7'b0110111;
                default: ;
            endcase
            case ($urandom_range(0, 2))
                0: f7 = 7'h00;
                1: f7 = 7'h20;
                default: f7 = 7'($urandom);
            endcase
            if (ins[6:0] == 7'b0110011 || ins[14:12] == 3'd1 || ins[14:12] == 3'd5)
                ins[31:25] = f7;
            run(ins, $urandom, $urandom, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/decode.md
Name: decode

Overview:
- RV32I integer decode/control unit for a multi-cycle core.
- Accepts one 32-bit instruction when the fetch side flags it ready.
- Reads source registers from the register file, drives operands and an operation code to a combinational ALU, then writes the ALU result back to the register file.
- Sits between fetch, register file (RF) and ALU.

Parameters:
- None. Widths are fixed at 32-bit data, 5-bit register address and 8-bit ALU opcode.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; one clock, synchronous, active-low.
- instruction_RDY_BSY  input  1  1 = instruction valid / fetch ready.
- instruction  input  32  RV32I instruction word.
- alu_result  input  32  combinational ALU result.
- alu_opcode  output  8  ALU operation code.
- alu_imm1  output  32  ALU operand A.
- alu_imm2  output  32  ALU operand B.
- RF_chip_enable  output  1  RF access enable.
- RF_write_enable  output  1  1 = write, 0 = read.
- RF_reg1_data  input  32  RF read data for rs1, combinational.
- RF_reg2_data  input  32  RF read data for rs2, combinational.
- RF_rs1_address  output  5  rs1 index.
- RF_rs2_address  output  5  rs2 index.
- RF_WR_add  output  5  write-back register index.
- RF_WriteData  output  32  write-back data.

Behaviour:
- All outputs are registered.
- When rst=0 at a clock edge: state=IDLE, all outputs = 0.
- Reset mid-operation abandons the instruction; no write occurs.
- FSM IDLE -> DECODE -> EXECUTE -> WRITEBACK -> IDLE; one cycle per state after IDLE.
- IDLE: RF_chip_enable=0, RF_write_enable=0. On an edge with instruction_RDY_BSY=1, latch instruction and go to DECODE; otherwise stay in IDLE. instruction is ignored in every other state.
- DECODE: RF_chip_enable=1, RF_write_enable=0, RF_rs1_address=instr[19:15], RF_rs2_address=instr[24:20]. At the closing edge, latch RF_reg1_data and RF_reg2_data.
- EXECUTE: RF_chip_enable=0.
  - alu_imm1 = rs1 data.
  - alu_imm2 = rs2 data for R-type (opcode 0110011); sign-extended instr[31:20] for I-ALU (0010011).
  - For shift immediates (funct3 001/101), alu_imm2 = zero-extended instr[24:20].
  - At the closing edge, latch alu_result.
- WRITEBACK:
  - RF_chip_enable=1, RF_WR_add=instr[11:7], RF_WriteData = latched result.
  - RF_write_enable=1 only if the instruction is legal and rd != 0; otherwise RF_write_enable=0.
  - Return to IDLE.
- alu_opcode codes:
  - NOP=0x00, ADD=0x01, SUB=0x02, SLL=0x03, SLT=0x04, SLTU=0x05, XOR=0x06, SRL=0x07, SRA=0x08, OR=0x09, AND=0x0A.
  - Selection is by funct3 / funct7[5].
  - SUB applies to R-type only; ADDI always maps to ADD.
  - SRAI/SRA are selected by instr[30].
- Illegal instructions (any other opcode, or bad funct7) still walk all states, with alu_opcode=NOP and no write.
- Throughput: one instruction per 4 cycles. Earliest next acceptance is in the IDLE cycle after WRITEBACK.
- Address, operand and opcode outputs hold their last values outside the states that drive them.

Optional Feature:
- Macro DECODE_LUI_EN.
- Defined: opcode 0110111 (LUI) is legal. DECODE does not enable the RF. EXECUTE drives alu_opcode=ADD, alu_imm1=0, alu_imm2={instr[31:12],12'b0}. WRITEBACK writes rd.
- Undefined: LUI is treated as illegal (NOP, no write).

Test Plan:
- Apply rst=0 for 2 edges -> all outputs 0, FSM in IDLE. Release rst=1 with instruction_RDY_BSY=0 -> FSM stays idle with RF_chip_enable=0.
- ADDI: instruction=0x00308113 (addi x2,x1,3) with RDY_BSY=1, RF_reg1_data=5, alu_result=8.
  - DECODE: rs1=1, CE=1, WE=0.
  - EXECUTE: alu_opcode=0x01, imm1=5, imm2=3.
  - WRITEBACK: WR_add=2, WriteData=8, CE=1, WE=1.
  - FSM returns to IDLE.
- SUB: instruction=0x40208133 (sub x2,x1,x2) with reg1=10, reg2=4 -> alu_opcode=0x02, imm1=10, imm2=4.
- SRAI: 0x4010D093 (srai x1,x1,1) -> alu_opcode=0x08, imm2=1. ADDI with imm=-1 (0xFFF00093) -> imm2=0xFFFFFFFF.
- Write suppression: addi x0,x1,3 -> WRITEBACK has WE=0. Opcode 0x0000007F -> NOP, WE=0.
- Reset mid-op: assert rst=0 during EXECUTE -> next cycle all outputs are 0, no write occurs, FSM is in IDLE.
